// File: rtl/mbo53_adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mbo53_adc_pkg
//  Description : Shared widths and FSM state encoding for the ADC averager.
//  Revision    : 1.0  initial release
// ============================================================================
package mbo53_adc_pkg;

    localparam int c_ADC_W    = 12;
    localparam int c_MAX_LOG2 = 7;
    localparam int c_ACC_W    = c_ADC_W + c_MAX_LOG2;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_ARM  = 2'd1;
    localparam state_t c_ST_ACC  = 2'd2;
    localparam state_t c_ST_DONE = 2'd3;

    function automatic logic [2:0] clamp_log2(input logic [2:0] val, input int max_log2);
        if (int'(val) > max_log2) begin
            return 3'(max_log2);
        end
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_frame_detect.sv
`default_nettype none
// ============================================================================
//  Module      : adc_frame_detect
//  Description : en edge detection; arms on the first frame start after start.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_frame_detect (
    input  logic clk_100,
    input  logic reset,
    input  logic start,
    input  logic en,
    output logic cap_stb,
    output logic armed
);

    logic r_en_d;

    always_ff @(posedge clk_100) begin
        if (reset) begin
            r_en_d <= 1'b0;
            armed  <= 1'b0;
        end else begin
            r_en_d <= en;
            if (!start) begin
                armed <= 1'b0;
            end else if (!en && r_en_d) begin
                armed <= 1'b1;
            end
        end
    end

    assign cap_stb = start & armed & en & ~r_en_d;

endmodule
`default_nettype wire

// File: rtl/adc_sample_avg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_avg
//  Description : Captures ADC results and reports mean/min/max per 2^k window.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_sample_avg
    import mbo53_adc_pkg::*;
#(
    parameter int DATA_LSB = 0,
    parameter int MAX_LOG2 = c_MAX_LOG2
) (
    input  logic                clk_100,
    input  logic                reset,
    input  logic                start,
    input  logic                en,
    input  logic [15:0]         adc_data,
    input  logic [2:0]          avg_log2,
    output logic [c_ADC_W-1:0]  sample_data,
    output logic                sample_valid,
    output logic [c_ADC_W-1:0]  avg_data,
    output logic [c_ADC_W-1:0]  min_data,
    output logic [c_ADC_W-1:0]  max_data,
    output logic                avg_valid,
    output logic                busy
);

    localparam int c_ACCW = c_ADC_W + MAX_LOG2;
    localparam int c_CNTW = MAX_LOG2 + 1;

    logic               w_cap_stb;
    logic               w_armed;
    logic               w_open;
    logic               w_unused;
    logic [c_ADC_W-1:0] w_sample;
    logic [2:0]         w_exp_in;
    logic [c_CNTW-1:0]  w_n_in;
    logic [c_CNTW-1:0]  w_n_cur;
    logic [c_CNTW-1:0]  w_cnt_inc;

    state_t             r_state;
    logic [c_ACCW-1:0]  r_acc;
    logic [c_CNTW-1:0]  r_cnt;
    logic [2:0]         r_exp;
    logic [c_ADC_W-1:0] r_min;
    logic [c_ADC_W-1:0] r_max;

    adc_frame_detect u_frame_detect (
        .clk_100 (clk_100),
        .reset   (reset),
        .start   (start),
        .en      (en),
        .cap_stb (w_cap_stb),
        .armed   (w_armed)
    );

    // Bits of the reader word outside the result field are deliberately ignored.
    assign w_unused  = ^adc_data;
    assign w_sample  = adc_data[DATA_LSB +: c_ADC_W];
    assign w_exp_in  = clamp_log2(avg_log2, MAX_LOG2);
    assign w_n_in    = c_CNTW'(1) << w_exp_in;
    assign w_n_cur   = c_CNTW'(1) << r_exp;
    assign w_cnt_inc = r_cnt + c_CNTW'(1);
    assign w_open    = ((r_state == c_ST_ARM) && w_armed) || (r_state == c_ST_DONE);

    always_ff @(posedge clk_100) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_exp        <= '0;
            r_min        <= '0;
            r_max        <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            avg_data     <= '0;
            min_data     <= '0;
            max_data     <= '0;
            avg_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= w_cap_stb;
            avg_valid    <= 1'b0;
            if (w_cap_stb) begin
                sample_data <= w_sample;
            end

            if (!start) begin
                r_state <= c_ST_IDLE;
                r_acc   <= '0;
                r_cnt   <= '0;
                busy    <= 1'b0;
            end else if (r_state == c_ST_IDLE) begin
                r_state <= c_ST_ARM;
            end else if (w_open) begin
                // Entering a new window: publish the finished one, latch the
                // exponent, and count a coincident capture as sample one.
                r_exp <= w_exp_in;
                busy  <= 1'b1;
                if (r_state == c_ST_DONE) begin
                    avg_data  <= c_ADC_W'(r_acc >> r_exp);
                    min_data  <= r_min;
                    max_data  <= r_max;
                    avg_valid <= 1'b1;
                end
                if (w_cap_stb) begin
                    r_acc   <= c_ACCW'(w_sample);
                    r_min   <= w_sample;
                    r_max   <= w_sample;
                    r_cnt   <= c_CNTW'(1);
                    r_state <= (w_n_in == c_CNTW'(1)) ? c_ST_DONE : c_ST_ACC;
                end else begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= c_ST_ACC;
                end
            end else if ((r_state == c_ST_ACC) && w_cap_stb) begin
                r_acc <= r_acc + c_ACCW'(w_sample);
                r_cnt <= w_cnt_inc;
                if (r_cnt == '0) begin
                    r_min <= w_sample;
                    r_max <= w_sample;
                end else begin
                    if (w_sample < r_min) r_min <= w_sample;
                    if (w_sample > r_max) r_max <= w_sample;
                end
                if (w_cnt_inc == w_n_cur) begin
                    r_state <= c_ST_DONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_avg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_sample_avg
//  Description : Directed self-checking bench with a window-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adc_sample_avg;

    logic        clk_100  = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        en       = 1'b0;
    logic [15:0] adc_data = 16'h0;
    logic [2:0]  avg_log2 = 3'd0;
    logic [11:0] sample_data, avg_data, min_data, max_data;
    logic        sample_valid, avg_valid, busy;

    adc_sample_avg #(.DATA_LSB(2), .MAX_LOG2(7)) dut (
        .clk_100      (clk_100),
        .reset        (reset),
        .start        (start),
        .en           (en),
        .adc_data     (adc_data),
        .avg_log2     (avg_log2),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .avg_data     (avg_data),
        .min_data     (min_data),
        .max_data     (max_data),
        .avg_valid    (avg_valid),
        .busy         (busy)
    );

    always #5 clk_100 = ~clk_100;

    int cyc = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    typedef struct { int val; int cyc; } s_exp_t;
    typedef struct { int avg; int mn; int mx; int cyc; } a_exp_t;

    s_exp_t exp_s[$];
    a_exp_t exp_a[$];
    s_exp_t es_c;
    a_exp_t ea_c;
    int     win_q[$];
    int     win_log  = 0;
    bit     m_armed  = 1'b0;
    bit     chk_on   = 1'b0;
    int     last_avg = 0, last_min = 0, last_max = 0;
    int     n_avg    = 0;
    int     n_vec    = 0, n_fail = 0;
    int     base;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    // Reference: every counted sample is echoed; a window closes after 2^k samples.
    task automatic model_sample(input int v, input int c);
        s_exp_t es;
        a_exp_t ea;
        int sum, mn, mx;
        es.val = v;
        es.cyc = c;
        exp_s.push_back(es);
        if (win_q.size() == 0) win_log = (avg_log2 > 3'd7) ? 7 : int'(avg_log2);
        win_q.push_back(v);
        if (win_q.size() == (1 << win_log)) begin
            sum = 0; mn = 4095; mx = 0;
            foreach (win_q[i]) begin
                sum += win_q[i];
                if (win_q[i] < mn) mn = win_q[i];
                if (win_q[i] > mx) mx = win_q[i];
            end
            ea.avg = sum >> win_log;
            ea.mn  = mn;
            ea.mx  = mx;
            ea.cyc = c + 1;
            exp_a.push_back(ea);
            win_q.delete();
        end
    endtask

    task automatic frame(input logic [11:0] v);
        bit was_hi;
        was_hi   = en;
        en       = 1'b0;
        adc_data = 16'(cyc * 40503);
        tick();
        if (was_hi && start) m_armed = 1'b1;
        tick();
        tick();
        adc_data = {2'b11, v, 2'b01};
        en       = 1'b1;
        if (start && m_armed) model_sample(int'(v), cyc + 1);
        tick(); tick(); tick();
    endtask

    // Drop start, choose the exponent, restart with a discarded frame-start edge.
    task automatic begin_run(input logic [2:0] lg);
        start = 1'b0;
        en    = 1'b0;
        tick();
        m_armed = 1'b0;
        win_q.delete();
        tick(); tick();
        avg_log2 = lg;
        start    = 1'b1;
        tick(); tick();
        adc_data = 16'hFFFF;
        en       = 1'b1;
        tick(); tick(); tick();
    endtask

    always @(negedge clk_100) begin
        if (chk_on) begin
            if (sample_valid) begin
                if (exp_s.size() == 0) begin
                    chk("unexpected_sample_valid", sample_valid, 0);
                end else begin
                    es_c = exp_s.pop_front();
                    chk("sample_data", sample_data, es_c.val);
                    chk("sample_latency", cyc, es_c.cyc);
                end
            end else if (exp_s.size() > 0 && exp_s[0].cyc < cyc) begin
                chk("sample_valid_missing", sample_valid, 1);
                void'(exp_s.pop_front());
            end

            if (avg_valid) begin
                n_avg++;
                if (exp_a.size() == 0) begin
                    chk("unexpected_avg_valid", avg_valid, 0);
                end else begin
                    ea_c = exp_a.pop_front();
                    chk("avg_data", avg_data, ea_c.avg);
                    chk("min_data", min_data, ea_c.mn);
                    chk("max_data", max_data, ea_c.mx);
                    chk("avg_latency", cyc, ea_c.cyc);
                    last_avg = ea_c.avg;
                    last_min = ea_c.mn;
                    last_max = ea_c.mx;
                end
            end else begin
                if (exp_a.size() > 0 && exp_a[0].cyc < cyc) begin
                    chk("avg_valid_missing", avg_valid, 1);
                    void'(exp_a.pop_front());
                end
                chk("avg_hold", avg_data, last_avg);
                chk("min_hold", min_data, last_min);
                chk("max_hold", max_data, last_max);
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (4) tick();
        chk("rst_sample_data", sample_data, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_avg_data", avg_data, 0);
        chk("rst_min_data", min_data, 0);
        chk("rst_max_data", max_data, 0);
        chk("rst_avg_valid", avg_valid, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        chk_on = 1'b1;

        // Basic window of four; the first rising edge after start is discarded
        begin_run(3'd2);
        chk("busy_before_arm", busy, 0);
        chk("no_sample_before_arm", int'(exp_s.size()), 0);
        frame(12'h100); frame(12'h200); frame(12'h300); frame(12'h400);
        tick(); tick();
        chk("w4_avg", avg_data, 12'h280);
        chk("w4_min", min_data, 12'h100);
        chk("w4_max", max_data, 12'h400);
        chk("w4_avg_pulses", n_avg, 1);
        chk("w4_busy", busy, 1);

        // Exponent change mid-window applies to the following window
        begin_run(3'd2);
        frame(12'h010); frame(12'h020);
        avg_log2 = 3'd0;
        base = n_avg;
        frame(12'h031);
        chk("exp_change_no_early", n_avg, base);
        frame(12'h045);
        chk("exp_change_avg", avg_data, 12'h029);
        chk("exp_change_min", min_data, 12'h010);
        chk("exp_change_max", max_data, 12'h045);
        frame(12'hABC); frame(12'h123); frame(12'h7FF);
        chk("n1_avg", avg_data, 12'h7FF);
        chk("n1_min", min_data, 12'h7FF);
        chk("n1_max", max_data, 12'h7FF);
        chk("n1_pulses", n_avg, base + 4);

        // Full-scale 128-sample window
        begin_run(3'd7);
        base = n_avg;
        repeat (127) frame(12'hFFF);
        chk("w128_not_early", n_avg, base);
        frame(12'hFFF);
        chk("w128_pulse", n_avg, base + 1);
        chk("w128_avg", avg_data, 12'hFFF);
        chk("w128_min", min_data, 12'hFFF);

        // Abort after five of eight samples, then a fresh window
        begin_run(3'd3);
        base = n_avg;
        for (int i = 1; i <= 5; i++) frame(12'(i * 12'h111));
        start = 1'b0;
        tick();
        m_armed = 1'b0;
        win_q.delete();
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_no_pulse", n_avg, base);
        chk("abort_avg_held", avg_data, 12'hFFF);
        begin_run(3'd3);
        for (int i = 1; i <= 7; i++) frame(12'(i));
        chk("restart_not_early", n_avg, base);
        frame(12'd8);
        chk("restart_pulse", n_avg, base + 1);
        chk("restart_avg", avg_data, 12'h004);
        chk("restart_min", min_data, 12'h001);
        chk("restart_max", max_data, 12'h008);

        // Reset mid-window
        begin_run(3'd2);
        frame(12'h300); frame(12'h500);
        reset = 1'b1;
        tick();
        m_armed = 1'b0;
        win_q.delete();
        exp_s.delete();
        exp_a.delete();
        last_avg = 0; last_min = 0; last_max = 0;
        chk("mid_rst_sample_data", sample_data, 0);
        chk("mid_rst_avg_data", avg_data, 0);
        chk("mid_rst_min_data", min_data, 0);
        chk("mid_rst_max_data", max_data, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_busy", busy, 0);
        base = n_avg;
        frame(12'h004); frame(12'h008); frame(12'h00C); frame(12'h010);
        chk("post_rst_pulse", n_avg, base + 1);
        chk("post_rst_avg", avg_data, 12'h00A);
        chk("post_rst_min", min_data, 12'h004);
        chk("post_rst_max", max_data, 12'h010);

        repeat (5) tick();
        chk("pending_samples", int'(exp_s.size()), 0);
        chk("pending_windows", int'(exp_a.size()), 0);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_sample_avg.md
ADC_SAMPLE_AVG -- requirements
Module: adc_sample_avg

Interface
REQ-001 Parameter DATA_LSB, 0, bit position in adc_data of the 12-bit conversion result LSB; the result is adc_data[DATA_LSB+11:DATA_LSB].
REQ-002 Parameter MAX_LOG2, 7, largest supported averaging exponent; window lengths are 1..128 samples.
REQ-003 clk_100  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  acquisition enable; the same signal that drives the ADC serial reader.
REQ-006 en  in  1  reader frame flag: low while bits shift, high when the frame is complete.
REQ-007 adc_data  in  16  reader shift-register contents.
REQ-008 avg_log2  in  3  averaging exponent; window length N = 2^avg_log2.
REQ-009 sample_data  out  12  most recent captured conversion result.
REQ-010 sample_valid  out  1  one-cycle strobe; sample_data updated this cycle.
REQ-011 avg_data  out  12  mean of the last completed window.
REQ-012 min_data  out  12  minimum over the last completed window.
REQ-013 max_data  out  12  maximum over the last completed window.
REQ-014 avg_valid  out  1  one-cycle strobe; avg_data, min_data and max_data updated this cycle.
REQ-015 busy  out  1  high while a window is being accumulated.

Function
REQ-016 A capture event SHALL be a rising edge of en (en=1 now, registered en=0 previous cycle) while start=1 and the block is armed.
REQ-017 The block SHALL become armed on the first falling edge of en after start rises, so the frame-start edge before any bits have shifted is discarded.
REQ-018 On a capture event the block SHALL register the result into sample_data and pulse sample_valid on the next cycle (latency 1).
REQ-019 FSM states: IDLE, ARM, ACC, DONE.
REQ-020 IDLE -> ARM when start=1; ARM -> ACC on the first falling edge of en; in ACC, capture events add to the accumulator; ACC -> DONE when the Nth sample is added; DONE -> ACC after one cycle with the accumulator cleared.
REQ-021 The exponent SHALL be latched from avg_log2 on entry to ACC; changes mid-window take effect from the next window.
REQ-022 avg_log2 values above MAX_LOG2 SHALL be clamped to MAX_LOG2.
REQ-023 The accumulator SHALL be 12+MAX_LOG2 bits (19 bits by default) so it cannot overflow.
REQ-024 avg_data SHALL equal accumulator >> exponent, truncated (no rounding).
REQ-025 min and max SHALL be seeded from the first sample of each window and compared against each later sample.
REQ-026 In DONE, avg_data, min_data and max_data SHALL load and avg_valid SHALL pulse for exactly one cycle; this is two cycles after the capture event of the Nth sample.
REQ-027 N=1 SHALL produce avg_data = min_data = max_data = that sample for every sample.
REQ-028 start falling in any state SHALL return the FSM to IDLE next cycle and discard the partial window, with no avg_valid pulse; avg_data, min_data and max_data keep their previous values.
REQ-029 busy SHALL be high in ACC and DONE, and low otherwise.
REQ-030 A capture event coinciding with DONE SHALL be counted as the first sample of the new window.

Reset
REQ-031 While reset=1 the FSM SHALL go to IDLE and be disarmed, and the registered en SHALL be set to 0.
REQ-032 While reset=1 the accumulator and sample counter SHALL be cleared.
REQ-033 While reset=1 all outputs SHALL be set to 0: sample_data, sample_valid, avg_data, min_data, max_data, avg_valid and busy.
REQ-034 Reset SHALL take priority over start and capture events in the same cycle.

Structure
REQ-035 The shared package mbo53_adc_pkg SHALL hold the ADC result width (12), MAX_LOG2 default, the accumulator width and the FSM state encoding.
REQ-036 The en edge detection and arming logic SHALL be a sub-module adc_frame_detect with outputs cap_stb and armed.

Verification
REQ-037 start=1, N=4, samples 0x100, 0x200, 0x300, 0x400 -> avg_data=0x280, min_data=0x100, max_data=0x400, avg_valid pulses exactly once.
REQ-038 First en rising edge after start (before any falling edge) -> no sample_valid; the first sample_valid follows the second rising edge.
REQ-039 N=128, all samples 0xFFF -> avg_data=0xFFF, with no accumulator wrap.
REQ-040 N=8, start dropped after 5 samples, then restarted -> no avg_valid for the aborted window, previous outputs held, the new window needs 8 fresh samples.
REQ-041 avg_log2 changed from 2 to 0 mid-window -> the current window still averages 4 samples; after that avg_valid follows every sample.
REQ-042 reset asserted mid-window -> all outputs 0 next cycle; after reset is released, arming again requires a falling edge of en.
